branch_resolver: RTL and testbench

Registered, handshaked branch-condition evaluator for the core's execute stage. Holds the architectural NZCV flag register, accepts branch requests carrying a condition code and a tag, and returns one registered take/not-take decision per request. Forwards same-cycle flag updates when configured, flags illegal condition codes, and keeps saturating taken/not-taken statistics for the performance monitor.

---
 rtl/branch_pkg.sv | 45 ++++
 rtl/branch_resolver_condition_eval.sv | 55 +++++
 rtl/branch_resolver.sv | 133 +++++++++++++
 tb/tb_branch_resolver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: condition code encodings,
// the NZCV flag struct and small helpers used by the evaluator and top.
package branch_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAGS_WIDTH = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

    function automatic logic [FLAGS_WIDTH-1:0] flags_to_bits(input flags_t f);
        return {f.n, f.z, f.c, f.v};
    endfunction

endpackage

// File: rtl/branch_resolver_condition_eval.sv
// Pure combinational map of (condition code, NZCV) to a take decision,
// shared with the decode-stage predictor check.
module branch_condition_eval
    import branch_pkg::*;
#(
    parameter int BRANCH_CONDITION_WIDTH = 4
) (
    input  logic [BRANCH_CONDITION_WIDTH-1:0] condition,
    input  flags_t                            flags,
    output logic                              take,
    output logic                              illegal
);

    logic [3:0] code;
    logic       raw_take;
    logic       n_eq_v;

    assign code   = condition[3:0];
    assign n_eq_v = (flags.n == flags.v);

    // Codes above 15 only exist when the field is wider than four bits.
    generate
        if (BRANCH_CONDITION_WIDTH > 4) begin : g_wide
            assign illegal = |condition[BRANCH_CONDITION_WIDTH-1:4];
        end else begin : g_narrow
            assign illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        raw_take = 1'b0;
        case (code)
            COND_EQ: raw_take = flags.z;
            COND_NE: raw_take = !flags.z;
            COND_CS: raw_take = flags.c;
            COND_CC: raw_take = !flags.c;
            COND_MI: raw_take = flags.n;
            COND_PL: raw_take = !flags.n;
            COND_VS: raw_take = flags.v;
            COND_VC: raw_take = !flags.v;
            COND_HI: raw_take = flags.c && !flags.z;
            COND_LS: raw_take = !flags.c || flags.z;
            COND_GE: raw_take = n_eq_v;
            COND_LT: raw_take = !n_eq_v;
            COND_GT: raw_take = !flags.z && n_eq_v;
            COND_LE: raw_take = flags.z || !n_eq_v;
            COND_AL: raw_take = 1'b1;
            COND_NV: raw_take = 1'b0;
            default: raw_take = 1'b0;
        endcase
    end

    assign take = raw_take && !illegal;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: NZCV register, optional same-cycle flag
// forwarding, single-entry handshaked result register and saturating stats.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int BRANCH_CONDITION_WIDTH = 4,
    parameter int TAG_WIDTH              = 4,
    parameter int COUNTER_WIDTH          = 16,
    parameter int FORWARD_FLAGS          = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flags_write,
    input  logic                              negative_in,
    input  logic                              zero_in,
    input  logic                              carry_in,
    input  logic                              overflow_in,
    input  logic                              request_valid,
    output logic                              request_ready,
    input  logic [BRANCH_CONDITION_WIDTH-1:0] condition,
    input  logic [TAG_WIDTH-1:0]              request_tag,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              take,
    output logic                              illegal,
    output logic [TAG_WIDTH-1:0]              result_tag,
    output logic [3:0]                        flags,
    input  logic                              counters_clear,
    output logic [COUNTER_WIDTH-1:0]          taken_count,
    output logic [COUNTER_WIDTH-1:0]          not_taken_count
);

    localparam logic                     FORWARD = (FORWARD_FLAGS != 0);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

    flags_t                     flags_d, flags_q;
    flags_t                     incoming_flags;
    flags_t                     eval_flags;
    logic                       result_valid_d, result_valid_q;
    logic                       take_d, take_q;
    logic                       illegal_d, illegal_q;
    logic [TAG_WIDTH-1:0]       result_tag_d, result_tag_q;
    logic [COUNTER_WIDTH-1:0]   taken_count_d, taken_count_q;
    logic [COUNTER_WIDTH-1:0]   not_taken_count_d, not_taken_count_q;
    logic                       accept;
    logic                       eval_take;
    logic                       eval_illegal;

    assign incoming_flags = pack_flags(negative_in, zero_in, carry_in, overflow_in);
    assign eval_flags     = (FORWARD && flags_write) ? incoming_flags : flags_q;

    assign request_ready  = !result_valid_q || result_ready;
    assign accept         = request_valid && request_ready;

    branch_condition_eval #(
        .BRANCH_CONDITION_WIDTH(BRANCH_CONDITION_WIDTH)
    ) u_eval (
        .condition(condition),
        .flags    (eval_flags),
        .take     (eval_take),
        .illegal  (eval_illegal)
    );

    always_comb begin
        flags_d = flags_q;
        if (flags_write) begin
            flags_d = incoming_flags;
        end
    end

    // A new accept overwrites the held result even while it is being
    // consumed, which gives back-to-back results with no bubble.
    always_comb begin
        result_valid_d = result_valid_q;
        take_d         = take_q;
        illegal_d      = illegal_q;
        result_tag_d   = result_tag_q;
        if (accept) begin
            result_valid_d = 1'b1;
            take_d         = eval_take;
            illegal_d      = eval_illegal;
            result_tag_d   = request_tag;
        end else if (result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_comb begin
        taken_count_d     = taken_count_q;
        not_taken_count_d = not_taken_count_q;
        if (counters_clear) begin
            taken_count_d     = '0;
            not_taken_count_d = '0;
        end else if (accept) begin
            if (eval_take) begin
                if (taken_count_q != COUNT_MAX) begin
                    taken_count_d = taken_count_q + 1'b1;
                end
            end else if (not_taken_count_q != COUNT_MAX) begin
                not_taken_count_d = not_taken_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q           <= '0;
            result_valid_q    <= 1'b0;
            take_q            <= 1'b0;
            illegal_q         <= 1'b0;
            result_tag_q      <= '0;
            taken_count_q     <= '0;
            not_taken_count_q <= '0;
        end else begin
            flags_q           <= flags_d;
            result_valid_q    <= result_valid_d;
            take_q            <= take_d;
            illegal_q         <= illegal_d;
            result_tag_q      <= result_tag_d;
            taken_count_q     <= taken_count_d;
            not_taken_count_q <= not_taken_count_d;
        end
    end

    assign result_valid    = result_valid_q;
    assign take            = take_q;
    assign illegal         = illegal_q;
    assign result_tag      = result_tag_q;
    assign flags           = flags_to_bits(flags_q);
    assign taken_count     = taken_count_q;
    assign not_taken_count = not_taken_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: a default instance (forwarding on) checked through
// a scoreboard, plus a narrow-counter, wide-condition, no-forwarding instance.
module tb_branch_resolver;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        a_fw, a_n, a_z, a_c, a_v;
    logic        a_req_valid, a_req_ready, a_res_valid, a_res_ready;
    logic        a_take, a_illegal, a_clear;
    logic [3:0]  a_cond, a_tag_in, a_res_tag, a_flags;
    logic [15:0] a_taken, a_not;

    logic        b_fw, b_n, b_z, b_c, b_v;
    logic        b_req_valid, b_req_ready, b_res_valid, b_res_ready;
    logic        b_take, b_illegal, b_clear;
    logic [4:0]  b_cond;
    logic [3:0]  b_tag_in, b_res_tag, b_flags;
    logic [2:0]  b_taken, b_not;

    branch_resolver dut_a (
        .clock(clock), .reset(reset), .flags_write(a_fw),
        .negative_in(a_n), .zero_in(a_z), .carry_in(a_c), .overflow_in(a_v),
        .request_valid(a_req_valid), .request_ready(a_req_ready),
        .condition(a_cond), .request_tag(a_tag_in),
        .result_valid(a_res_valid), .result_ready(a_res_ready),
        .take(a_take), .illegal(a_illegal), .result_tag(a_res_tag),
        .flags(a_flags), .counters_clear(a_clear),
        .taken_count(a_taken), .not_taken_count(a_not)
    );

    branch_resolver #(
        .BRANCH_CONDITION_WIDTH(5), .TAG_WIDTH(4), .COUNTER_WIDTH(3), .FORWARD_FLAGS(0)
    ) dut_b (
        .clock(clock), .reset(reset), .flags_write(b_fw),
        .negative_in(b_n), .zero_in(b_z), .carry_in(b_c), .overflow_in(b_v),
        .request_valid(b_req_valid), .request_ready(b_req_ready),
        .condition(b_cond), .request_tag(b_tag_in),
        .result_valid(b_res_valid), .result_ready(b_res_ready),
        .take(b_take), .illegal(b_illegal), .result_tag(b_res_tag),
        .flags(b_flags), .counters_clear(b_clear),
        .taken_count(b_taken), .not_taken_count(b_not)
    );

    typedef struct {
        bit         take;
        bit         illegal;
        logic [3:0] tag;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    exp_t       item;
    logic [3:0] m_flags;
    bit         m_valid;
    int         m_taken, m_not;
    int         n_checks, n_fail;
    int         saved_taken;

    function automatic bit ref_take(input int code, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drives dut_a for one cycle, updates the reference model and pushes the
    // expected result of any accepted request, then waits past the edge.
    task automatic applyStimulus(input bit valid, input int code, input int tag,
                                 input bit rr, input bit fw, input logic [3:0] nf,
                                 input bit clr);
        logic [3:0] ef;
        bit acc, t;
        a_req_valid = valid; a_cond = code[3:0]; a_tag_in = tag[3:0];
        a_res_ready = rr; a_fw = fw; {a_n, a_z, a_c, a_v} = nf; a_clear = clr;
        ef  = fw ? nf : m_flags;
        acc = valid && (!m_valid || rr);
        t   = ref_take(code, ef);
        if (acc) begin
            item.take = t; item.illegal = 1'b0; item.tag = tag[3:0];
            sb.push_back(item);
        end
        if (clr) begin
            m_taken = 0; m_not = 0;
        end else if (acc) begin
            if (t) m_taken = (m_taken == 65535) ? m_taken : m_taken + 1;
            else   m_not   = (m_not   == 65535) ? m_not   : m_not + 1;
        end
        if (fw) m_flags = nf;
        if (acc) m_valid = 1'b1;
        else if (rr) m_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic b_idle();
        b_req_valid = 0; b_cond = '0; b_tag_in = '0; b_res_ready = 1;
        b_fw = 0; {b_n, b_z, b_c, b_v} = 4'b0; b_clear = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        applyStimulus(1, 14, 6, 1, 1, 4'b1111, 0);
        b_req_valid = 1; b_cond = 5'd14; b_fw = 1; {b_n, b_z, b_c, b_v} = 4'b1111;
        applyStimulus(1, 14, 6, 1, 1, 4'b1111, 0);
        b_idle();
        m_flags = 0; m_valid = 0; m_taken = 0; m_not = 0; sb.delete();
        n_checks++; if (a_flags !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", a_flags); end
        n_checks++; if (a_res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", a_res_valid); end
        n_checks++; if ({a_take, a_illegal, a_res_tag} !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_result: got %b want 0", {a_take, a_illegal, a_res_tag}); end
        n_checks++; if ({a_taken, a_not} !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_counts: got %h want 0", {a_taken, a_not}); end
        n_checks++; if ({b_flags, b_res_valid, b_taken, b_not} !== 11'd0) begin n_fail++; $display("[TB] FAIL reset_b: got %h want 0", {b_flags, b_res_valid, b_taken, b_not}); end
        reset = 0;
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_reset: got %b want 1", a_req_ready); end
    endtask

    task automatic test_basic();
        applyStimulus(0, 0, 0, 1, 1, 4'b0100, 0);
        n_checks++; if (a_flags !== 4'b0100) begin n_fail++; $display("[TB] FAIL flags_write: got %b want 0100", a_flags); end
        applyStimulus(1, 0, 5, 1, 0, 4'b0, 0);
        n_checks++; if (a_res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b want 1", a_res_valid); end
        cur = sb.pop_front();
        n_checks++; if ({a_take, a_res_tag} !== {cur.take, cur.tag}) begin n_fail++; $display("[TB] FAIL basic_result: got %b/%0d want %b/%0d", a_take, a_res_tag, cur.take, cur.tag); end
        n_checks++; if (a_taken !== 16'(m_taken)) begin n_fail++; $display("[TB] FAIL basic_taken_count: got %0d want %0d", a_taken, m_taken); end
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            applyStimulus(0, 0, 0, 1, 1, f[3:0], 0);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1, c, c, 1, 0, 4'b0, 0);
                n_checks++;
                if (a_res_valid !== 1'b1 || sb.size() != 1) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_valid f=%0d c=%0d: got %b want 1", f, c, a_res_valid);
                    sb.delete();
                end else begin
                    cur = sb.pop_front();
                    if ({a_take, a_illegal, a_res_tag} !== {cur.take, cur.illegal, cur.tag}) begin
                        n_fail++;
                        $display("[TB] FAIL sweep_take f=%0d c=%0d: got %b%b/%0d want %b%b/%0d",
                                 f, c, a_take, a_illegal, a_res_tag, cur.take, cur.illegal, cur.tag);
                    end
                end
            end
        end
        n_checks++; if ({a_taken, a_not} !== {16'(m_taken), 16'(m_not)}) begin n_fail++; $display("[TB] FAIL sweep_counts: got %0d/%0d want %0d/%0d", a_taken, a_not, m_taken, m_not); end
    endtask

    task automatic test_forward();
        b_fw = 1; {b_n, b_z, b_c, b_v} = 4'b0000;
        applyStimulus(0, 0, 0, 1, 1, 4'b0000, 0);
        b_req_valid = 1; b_cond = 5'd0; b_tag_in = 4'd7; b_fw = 1; {b_n, b_z, b_c, b_v} = 4'b0100;
        applyStimulus(1, 0, 7, 1, 1, 4'b0100, 0);
        b_idle();
        cur = sb.pop_front();
        n_checks++; if (a_take !== 1'b1 || cur.take !== 1'b1) begin n_fail++; $display("[TB] FAIL forward_on: got %b want 1", a_take); end
        n_checks++; if ({b_res_valid, b_take} !== 2'b10) begin n_fail++; $display("[TB] FAIL forward_off: got %b want 10", {b_res_valid, b_take}); end
        n_checks++; if (b_not !== 3'd1) begin n_fail++; $display("[TB] FAIL forward_off_count: got %0d want 1", b_not); end
    endtask

    task automatic test_backpressure();
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
        applyStimulus(1, 14, 9, 0, 0, 4'b0, 0);
        cur = sb.pop_front();
        saved_taken = m_taken;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 15, 2, 0, 0, 4'b0, 0);
            n_checks++;
            if ({a_req_ready, a_res_valid, a_take, a_res_tag} !== {2'b01, cur.take, cur.tag} ||
                a_taken !== 16'(saved_taken) || sb.size() != 0) begin
                n_fail++;
                $display("[TB] FAIL stall_%0d: got rdy=%b v=%b t=%b tag=%0d cnt=%0d want rdy=0 v=1 t=%b tag=%0d cnt=%0d",
                         i, a_req_ready, a_res_valid, a_take, a_res_tag, a_taken, cur.take, cur.tag, saved_taken);
            end
        end
        applyStimulus(1, 15, 3, 1, 0, 4'b0, 0);
        n_checks++;
        if (sb.size() != 1) begin
            n_fail++; $display("[TB] FAIL release_accept: got queue %0d want 1", sb.size());
            sb.delete();
        end else begin
            cur = sb.pop_front();
            if ({a_req_ready, a_take, a_res_tag} !== {1'b1, cur.take, cur.tag} || a_not !== 16'(m_not)) begin
                n_fail++;
                $display("[TB] FAIL release_result: got rdy=%b t=%b tag=%0d nt=%0d want rdy=1 t=%b tag=%0d nt=%0d",
                         a_req_ready, a_take, a_res_tag, a_not, cur.take, cur.tag, m_not);
            end
        end
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
    endtask

    task automatic test_illegal_and_saturation();
        b_req_valid = 1; b_cond = 5'd20; b_tag_in = 4'd11;
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
        n_checks++; if ({b_res_valid, b_take, b_illegal, b_res_tag} !== {3'b101, 4'd11}) begin n_fail++; $display("[TB] FAIL illegal: got v=%b t=%b i=%b tag=%0d want 1/0/1/11", b_res_valid, b_take, b_illegal, b_res_tag); end
        n_checks++; if ({b_taken, b_not} !== {3'd0, 3'd2}) begin n_fail++; $display("[TB] FAIL illegal_count: got %0d/%0d want 0/2", b_taken, b_not); end
        b_cond = 5'd14;
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
        n_checks++; if ({b_taken, b_not, b_illegal} !== {3'd7, 3'd2, 1'b0}) begin n_fail++; $display("[TB] FAIL saturate: got %0d/%0d/%b want 7/2/0", b_taken, b_not, b_illegal); end
        b_clear = 1;
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
        n_checks++; if ({b_taken, b_not, b_take} !== {3'd0, 3'd0, 1'b1}) begin n_fail++; $display("[TB] FAIL clear_priority: got %0d/%0d/%b want 0/0/1", b_taken, b_not, b_take); end
        b_idle();
        applyStimulus(0, 0, 0, 1, 0, 4'b0, 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        b_idle();
        test_reset();
        test_basic();
        test_sweep();
        test_forward();
        test_backpressure();
        test_illegal_and_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
